// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC captures, RESP holds the response.
package alu_arbiter_pkg;

    typedef logic [3:0] alu_control_t;

    localparam alu_control_t ALU_AND  = 4'd1;
    localparam alu_control_t ALU_OR   = 4'd2;
    localparam alu_control_t ALU_XOR  = 4'd3;
    localparam alu_control_t ALU_SLL  = 4'd5;
    localparam alu_control_t ALU_SRL  = 4'd6;
    localparam alu_control_t ALU_SRA  = 4'd7;
    localparam alu_control_t ALU_ADD  = 4'd8;
    localparam alu_control_t ALU_SUB  = 4'd12;
    localparam alu_control_t ALU_SLT  = 4'd13;
    localparam alu_control_t ALU_SLTU = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  alu_control_t req0_control,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  alu_control_t req1_control,

    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic         resp1_valid,
    input  logic         resp1_ready,

    output logic [N-1:0] resp_result,
    output logic         resp_overflow,
    output logic         resp_zero,
    output logic         resp_equal,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_control_t alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_overflow,
    input  logic         alu_zero,
    input  logic         alu_equal,

    output arb_state_t   debug_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high. Requesters hold valid/operands until ready; responses stay valid and
    // stable until the requester's resp ready is seen at an edge. Ready never
    // depends on anything but state, priority and the two request valids.

    arb_state_t   state;
    logic         prio;
    logic         grant;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    alu_control_t ctrl_q;

    logic accept;
    logic pick1;
    logic resp_done;

    // Preferred port wins if valid; otherwise the other port takes the slot.
    always_comb begin
        pick1  = prio ? req1_valid : !req0_valid;
        accept = (state == ST_IDLE) && (req0_valid || req1_valid) && !rst;
    end

    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;
    assign resp_done  = grant ? resp1_ready : resp0_ready;

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
    assign debug_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            prio          <= 1'b0;
            grant         <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_equal    <= 1'b0;
            resp0_valid   <= 1'b0;
            resp1_valid   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q    <= pick1 ? req1_a : req0_a;
                        b_q    <= pick1 ? req1_b : req0_b;
                        ctrl_q <= pick1 ? req1_control : req0_control;
                        grant  <= pick1;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_result   <= alu_result;
                    resp_overflow <= alu_overflow;
                    resp_zero     <= alu_zero;
                    resp_equal    <= alu_equal;
                    resp0_valid   <= !grant;
                    resp1_valid   <= grant;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    // Hand priority to the port that just waited.
                    if (resp_done) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        prio        <= !grant;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop and each
// step is checked with an immediate assertion against hand-computed values.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    alu_control_t req0_control, req1_control;
    logic         resp0_valid, resp1_valid;
    logic         resp0_ready, resp1_ready;
    logic [N-1:0] resp_result;
    logic         resp_overflow, resp_zero, resp_equal;
    logic [N-1:0] alu_a, alu_b, alu_result;
    alu_control_t alu_control;
    logic         alu_overflow, alu_zero, alu_equal;
    arb_state_t   debug_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_control(req0_control),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_control(req1_control),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_zero(resp_zero), .resp_equal(resp_equal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_equal(alu_equal),
        .debug_state(debug_state)
    );

    // Shared ALU seen by the arbiter; unused opcodes give 0.
    logic [N-1:0] tmp;
    always_comb begin
        tmp          = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_control)
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $signed(alu_a) >>> alu_b[4:0];
            ALU_ADD: begin
                tmp          = alu_a + alu_b;
                alu_result   = tmp;
                alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (tmp[N-1] != alu_a[N-1]);
            end
            ALU_SUB: begin
                tmp          = alu_a - alu_b;
                alu_result   = tmp;
                alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (tmp[N-1] != alu_a[N-1]);
            end
            ALU_SLT:  alu_result = {{(N-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {{(N-1){1'b0}}, alu_a < alu_b};
            default:  alu_result = '0;
        endcase
        alu_zero  = (alu_result == '0);
        alu_equal = (alu_a == alu_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_port;
        logic [31:0] exp_res;

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_control = '0;
        req1_a = '0; req1_b = '0; req1_control = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        // Reset state, with a request pending that must not be accepted
        tick(); tick();
        chk("rst_req0_ready", 32'(req0_ready), 0);
        chk("rst_resp0_valid", 32'(resp0_valid), 0);
        chk("rst_resp1_valid", 32'(resp1_valid), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_control", 32'(alu_control), 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_state", 32'(debug_state), 32'(ST_IDLE));
        req0_valid = 1'b0;
        rst = 1'b0;

        // Single ADD on port 0; resp ready early must be ignored while resp invalid
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_control = ALU_ADD;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF; resp0_ready = 1'b1;
        #1;
        chk("t1_exec_state", 32'(debug_state), 32'(ST_EXEC));
        chk("t1_alu_a", alu_a, 32'd5);
        chk("t1_alu_b", alu_b, 32'd7);
        chk("t1_alu_control", 32'(alu_control), 32'(ALU_ADD));
        chk("t1_exec_ready", 32'(req0_ready), 0);
        chk("t1_exec_resp0", 32'(resp0_valid), 0);
        tick();
        chk("t1_resp0_valid", 32'(resp0_valid), 1);
        chk("t1_resp1_valid", 32'(resp1_valid), 0);
        chk("t1_result", resp_result, 32'd12);
        chk("t1_overflow", 32'(resp_overflow), 0);
        chk("t1_zero", 32'(resp_zero), 0);
        tick();
        resp0_ready = 1'b0;
        chk("t1_done_valid", 32'(resp0_valid), 0);
        chk("t1_done_state", 32'(debug_state), 32'(ST_IDLE));

        // Unused opcode returns 0 with zero flag
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_control = 4'd9;
        tick();
        req0_valid = 1'b0;
        tick();
        chk("nop_valid", 32'(resp0_valid), 1);
        chk("nop_result", resp_result, 0);
        chk("nop_zero", 32'(resp_zero), 1);
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;

        // Contention from reset: port 0 wins first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_control = ALU_SUB;
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_control = ALU_SLT;
        #1;
        chk("c_req0_ready", 32'(req0_ready), 1);
        chk("c_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("c_exec_req1_held", 32'(req1_ready), 0);
        tick();
        chk("c_resp0_valid", 32'(resp0_valid), 1);
        chk("c_resp1_valid", 32'(resp1_valid), 0);
        chk("c_sub_result", resp_result, 0);
        chk("c_sub_zero", 32'(resp_zero), 1);
        chk("c_sub_equal", 32'(resp_equal), 1);
        chk("c_resp_req1_held", 32'(req1_ready), 0);
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        // Port 1 now preferred even with port 0 valid again
        req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_control = ALU_AND;
        #1;
        chk("c_idle_state", 32'(debug_state), 32'(ST_IDLE));
        chk("c_rr_req1_ready", 32'(req1_ready), 1);
        chk("c_rr_req0_ready", 32'(req0_ready), 0);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("c_resp1_valid", 32'(resp1_valid), 1);
        chk("c_slt_result", resp_result, 32'd1);

        // Backpressure on port 1 for 5 cycles; port 0 stays held off
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_resp1_valid", 32'(resp1_valid), 1);
            chk("bp_result", resp_result, 32'd1);
            chk("bp_req0_ready", 32'(req0_ready), 0);
            chk("bp_req1_ready", 32'(req1_ready), 0);
        end
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;
        // Priority back to port 0
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_control = ALU_ADD;
        #1;
        chk("c_back_req0_ready", 32'(req0_ready), 1);
        chk("c_back_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("and_resp0_valid", 32'(resp0_valid), 1);
        chk("and_result", resp_result, 32'hF000_F000);
        resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;

        // Signed overflow on port 1
        #1;
        chk("ovf_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("ovf_resp1_valid", 32'(resp1_valid), 1);
        chk("ovf_result", resp_result, 32'h8000_0000);
        chk("ovf_flag", 32'(resp_overflow), 1);
        chk("ovf_zero", 32'(resp_zero), 0);
        resp1_ready = 1'b1;
        tick();
        resp1_ready = 1'b0;

        // Reset during EXEC abandons the operation
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_control = ALU_ADD;
        tick();
        req0_valid = 1'b0;
        chk("rm_exec_state", 32'(debug_state), 32'(ST_EXEC));
        rst = 1'b1;
        #1;
        chk("rm_state", 32'(debug_state), 32'(ST_IDLE));
        chk("rm_alu_a", alu_a, 0);
        chk("rm_alu_b", alu_b, 0);
        chk("rm_alu_control", 32'(alu_control), 0);
        chk("rm_result", resp_result, 0);
        chk("rm_overflow", 32'(resp_overflow), 0);
        chk("rm_resp0_valid", 32'(resp0_valid), 0);
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rm_after_resp0", 32'(resp0_valid), 0);
            chk("rm_after_resp1", 32'(resp1_valid), 0);
        end

        // Fairness: both ports valid for 10 operations
        req0_valid = 1'b1; req0_control = ALU_ADD;
        req1_valid = 1'b1; req1_control = ALU_SUB;
        for (int op = 0; op < 10; op++) begin
            exp_port = op % 2;
            req0_a = 32'(op); req0_b = 32'd10;
            req1_a = 32'd100; req1_b = 32'(op);
            exp_res = (exp_port == 0) ? 32'(op + 10) : 32'(100 - op);
            #1;
            chk("fair_req0_ready", 32'(req0_ready), 32'(exp_port == 0));
            chk("fair_req1_ready", 32'(req1_ready), 32'(exp_port == 1));
            tick();
            tick();
            chk("fair_resp0_valid", 32'(resp0_valid), 32'(exp_port == 0));
            chk("fair_resp1_valid", 32'(resp1_valid), 32'(exp_port == 1));
            chk("fair_result", resp_result, exp_res);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqK_valid  input  1  (K=0,1) requester K presents an operation.
REQ-005 reqK_ready  output  1  (K=0,1) operation accepted this cycle.
REQ-006 reqK_a, reqK_b  input  N  (K=0,1) operands.
REQ-007 reqK_control  input  4  (K=0,1) ALU opcode, type alu_control_t.
REQ-008 respK_valid  output  1  (K=0,1) response held for requester K.
REQ-009 respK_ready  input  1  (K=0,1) requester K consumes the response.
REQ-010 resp_result  output  N  captured ALU result, shared by both response ports.
REQ-011 resp_overflow, resp_zero, resp_equal  output  1 each  captured ALU flags.
REQ-012 alu_a, alu_b  output  N  operands driven to the shared ALU.
REQ-013 alu_control  output  4  opcode driven to the shared ALU.
REQ-014 alu_result  input  N; alu_overflow, alu_zero, alu_equal  input  1 each  combinational ALU outputs.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; exactly one state at a time.
REQ-016 IDLE: if any reqK_valid, grant one requester, assert its reqK_ready combinationally that cycle, latch its a/b/control, record grant, go EXEC; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: a priority bit selects the preferred port; the grant goes to the preferred port if it is valid, otherwise to the other port.
REQ-018 Priority bit SHALL move to the non-granted port on each completed handshake in RESP.
REQ-019 At most one reqK_ready SHALL be high in any cycle; reqK_ready SHALL be low outside IDLE.
REQ-020 alu_a/alu_b/alu_control SHALL be driven from the latched registers in all states (zero after reset).
REQ-021 EXEC: capture alu_result and the three flags into resp_* registers at the clock edge, go RESP (one-cycle execute).
REQ-022 RESP: respK_valid high only for the granted K; held with resp_* stable until respK_ready is high at a clock edge, then go IDLE.
REQ-023 Latency: request accepted at edge T yields respK_valid high from cycle after edge T+1; minimum issue interval 3 cycles.
REQ-024 respK_ready asserted while respK_valid is low SHALL be ignored.
REQ-025 The opposite port's request SHALL be held off (ready low) during EXEC/RESP; its valid and operands are not sampled.
REQ-026 Opcodes SHALL pass unmodified; unused codes (0,4,9,10,11,14) produce the ALU's result of 0 with zero=1, returned normally.
REQ-027 Response in RESP and a new request may not overlap: the IDLE cycle after handshake is mandatory.
REQ-028 Operands SHALL NOT be modified by the arbiter; widths are N throughout, no extension or truncation.

Reset
REQ-029 While rst is high: state IDLE, priority to port 0, latched a/b/control = 0, resp_* = 0, respK_valid = 0, reqK_ready = 0.
REQ-030 rst asserted mid-operation (EXEC or RESP) SHALL abandon the operation; no response is delivered after release.
REQ-031 First IDLE evaluation occurs on the first rising edge after rst deasserts.

Verification
REQ-032 Single op: req0 ADD(8) a=5, b=7 -> req0_ready one cycle, resp0_valid 2 edges later, resp_result=12, overflow=0, zero=0.
REQ-033 Contention: req0 and req1 valid together from reset, req0 SUB a=3,b=3, req1 SLT a=-1,b=1 -> port0 first (result 0, zero=1, equal=1), then port1 (result 1); priority returns to port 0.
REQ-034 Backpressure: resp1_ready held low 5 cycles after resp1_valid -> resp1_valid and resp_result stable all 5 cycles; no reqK_ready in that window.
REQ-035 Overflow: req1 ADD a=0x7FFFFFFF, b=1 -> resp_result=0x80000000, resp_overflow=1.
REQ-036 Reset mid-op: rst pulsed during EXEC -> all outputs 0, no resp0/resp1 valid afterward until a new request.
REQ-037 Fairness: both ports valid continuously for 10 ops -> grants strictly alternate 0,1,0,1,...
